pps_transmitter: RTL

//  Generates a local 1PPS pulse train plus a seconds count from ptp_clk for boards acting as timing master.
//  It is the source end of the 1PPS link that pps_receiver consumes.

---
 rtl/pps_pkg.sv | 21 ++
 rtl/pps_transmitter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pps_pkg.sv
// -----------------------------------------------------------------------------
// pps_pkg
// Shared declarations for the 1PPS link blocks (pps_transmitter, pps_receiver).
//   pps_state_t    : pulse-train controller state
//   pps_cycles()   : ptp_clk frequency in kHz -> cycles per second
//   PPS_SEC_WIDTH  : width of the seconds counter
// -----------------------------------------------------------------------------
package pps_pkg;

    typedef enum logic {
        PPS_IDLE,
        PPS_RUN
    } pps_state_t;

    localparam int PPS_SEC_WIDTH = 32;

    function automatic int pps_cycles(input int freq_khz);
        return freq_khz * 1000;
    endfunction

endpackage

// File: rtl/pps_transmitter.sv
// -----------------------------------------------------------------------------
// pps_transmitter
// Local 1PPS source for a timing master. A free-running period counter on
// ptp_clk produces pps_out (C_PULSE_CYCLES wide), a one-cycle pps_strobe at
// the start of each pulse and a seconds count. The servo/CPU can stretch or
// shrink a single period through a valid/ready phase-adjust port.
//
// Parameters
//   C_CLOCK_FREQUENCY  ptp_clk frequency in kHz (nominal period P = kHz*1000)
//   C_PULSE_CYCLES     pps_out high time, 1 <= C_PULSE_CYCLES < P/2
//   C_ADJ_WIDTH        width of the signed phase-adjust word
//
// Ports
//   ptp_clk     in   core clock
//   ptp_rst     in   synchronous active-high reset
//   enable      in   1 = run the pulse train, 0 = idle
//   adj_valid   in   phase-adjust request
//   adj_ready   out  adjust slot free
//   adj_data    in   signed cycles added to one period length
//   pps_align   in   one-cycle strobe forcing a new second (PPS_TX_ALIGN_EN)
//   pps_out     out  1PPS pulse to pad
//   pps_strobe  out  one-cycle strobe on the first cycle of each pulse
//   sec_cnt     out  seconds elapsed, advances after each strobe
//
// Build option
//   PPS_TX_ALIGN_EN  adds pps_align; undefined builds have no such port.
//
// States
//   PPS_IDLE | counter parked at 0, outputs low, waiting for enable
//   PPS_RUN  | counter runs 0..len and wraps, one pulse per wrap
// -----------------------------------------------------------------------------
module pps_transmitter
    import pps_pkg::*;
#(
    parameter int C_CLOCK_FREQUENCY = 25000,
    parameter int C_PULSE_CYCLES    = 2500,
    parameter int C_ADJ_WIDTH       = 16
) (
    input  logic                     ptp_clk,
    input  logic                     ptp_rst,
    input  logic                     enable,
    input  logic                     adj_valid,
    output logic                     adj_ready,
    input  logic [C_ADJ_WIDTH-1:0]   adj_data,
`ifdef PPS_TX_ALIGN_EN
    input  logic                     pps_align,
`endif
    output logic                     pps_out,
    output logic                     pps_strobe,
    output logic [PPS_SEC_WIDTH-1:0] sec_cnt
);

    localparam int P      = pps_cycles(C_CLOCK_FREQUENCY);
    localparam int HALF_P = P / 2;
    localparam int LEN_W  = $clog2(P + 2**(C_ADJ_WIDTH-1));

    localparam logic [LEN_W-1:0]        LEN_NOM   = LEN_W'(P - 1);
    localparam logic [LEN_W-1:0]        PULSE_LEN = LEN_W'(C_PULSE_CYCLES);
    localparam logic signed [LEN_W:0]   HALF_S    = (LEN_W+1)'(HALF_P);
    localparam logic signed [LEN_W:0]   NEG_S     = -HALF_S;

    pps_state_t               state;
    pps_state_t               state_nxt;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         cnt_nxt;
    logic [LEN_W-1:0]         len;
    logic [LEN_W-1:0]         len_nxt;
    logic [LEN_W-1:0]         pending;
    logic [LEN_W-1:0]         pending_nxt;
    logic                     pend_valid;
    logic                     pend_valid_nxt;
    logic                     pps_out_nxt;
    logic                     pps_strobe_nxt;
    logic [PPS_SEC_WIDTH-1:0] sec_cnt_nxt;

    logic                     align_hit;
    logic                     xfer;
    logic signed [LEN_W:0]    adj_ext;
    logic [LEN_W-1:0]         adj_sat;

`ifdef PPS_TX_ALIGN_EN
    assign align_hit = pps_align;
`else
    assign align_hit = 1'b0;
`endif

    assign adj_ready = ~pend_valid;
    assign xfer      = adj_valid & adj_ready;

    // Clamp the request to +/- P/2 so the adjusted period never drops below
    // the pulse width. The clamped value is kept in LEN_W-bit two's
    // complement; adding it modulo 2^LEN_W to P-1 yields the true length.
    always_comb begin
        adj_ext = {{(LEN_W+1-C_ADJ_WIDTH){adj_data[C_ADJ_WIDTH-1]}}, adj_data};
        if (adj_ext > HALF_S) begin
            adj_sat = HALF_S[LEN_W-1:0];
        end else if (adj_ext < NEG_S) begin
            adj_sat = NEG_S[LEN_W-1:0];
        end else begin
            adj_sat = adj_ext[LEN_W-1:0];
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        len_nxt        = len;
        pending_nxt    = pending;
        pend_valid_nxt = pend_valid;
        pps_out_nxt    = 1'b0;
        pps_strobe_nxt = 1'b0;
        sec_cnt_nxt    = sec_cnt;

        if (pps_strobe) begin
            sec_cnt_nxt = sec_cnt + PPS_SEC_WIDTH'(1);
        end

        case (state)
            PPS_IDLE: begin
                cnt_nxt = '0;
                len_nxt = LEN_NOM;
                if (enable) begin
                    state_nxt = PPS_RUN;
                end
            end
            PPS_RUN: begin
                if (!enable) begin
                    state_nxt = PPS_IDLE;
                    cnt_nxt   = '0;
                    len_nxt   = LEN_NOM;
                end else begin
                    pps_out_nxt    = (cnt < PULSE_LEN);
                    pps_strobe_nxt = (cnt == '0);
                    if (align_hit) begin
                        // Restart the second; a pending adjust waits for
                        // the next real wrap.
                        cnt_nxt = '0;
                        len_nxt = LEN_NOM;
                    end else if (cnt == len) begin
                        cnt_nxt        = '0;
                        len_nxt        = pend_valid ? (LEN_NOM + pending) : LEN_NOM;
                        pend_valid_nxt = 1'b0;
                        pending_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = PPS_IDLE;
            end
        endcase

        // A transfer can only happen with the slot empty, so it never
        // collides with the wrap-time release above; a transfer in the wrap
        // cycle therefore lands after that wrap's reload.
        if (xfer) begin
            pend_valid_nxt = 1'b1;
            pending_nxt    = adj_sat;
        end

        if ((state == PPS_RUN) && !enable) begin
            pend_valid_nxt = 1'b0;
            pending_nxt    = '0;
        end
    end

    always_ff @(posedge ptp_clk) begin
        if (ptp_rst) begin
            state      <= PPS_IDLE;
            cnt        <= '0;
            len        <= LEN_NOM;
            pending    <= '0;
            pend_valid <= 1'b0;
            pps_out    <= 1'b0;
            pps_strobe <= 1'b0;
            sec_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            len        <= len_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
            pps_out    <= pps_out_nxt;
            pps_strobe <= pps_strobe_nxt;
            sec_cnt    <= sec_cnt_nxt;
        end
    end

endmodule
